serv_mtimer: RTL

SERV_MTIMER -- requirements
Module: serv_mtimer

---
 rtl/serv_mtimer_pkg.sv | 10 +
 rtl/serv_mtimer_bytewr.sv | 19 +
 rtl/serv_mtimer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/serv_mtimer_pkg.sv
// Shared definitions for the machine timer: the word offsets of the four
// bus-visible 32-bit registers.
package serv_mtimer_pkg;

    localparam logic [1:0] MTIME_LO    = 2'd0;
    localparam logic [1:0] MTIME_HI    = 2'd1;
    localparam logic [1:0] MTIMECMP_LO = 2'd2;
    localparam logic [1:0] MTIMECMP_HI = 2'd3;

endpackage

// File: rtl/serv_mtimer_bytewr.sv
// Byte-enable merge for one 32-bit word. A selected byte takes the new value
// and an unselected byte keeps the old value.
module serv_mtimer_bytewr (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_sel,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old;
        for (int b = 0; b < 4; b++) begin
            if (i_sel[b]) begin
                o_merged[8*b +: 8] = i_new[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/serv_mtimer.sv
// Memory-mapped RISC-V machine timer: prescaled 64-bit mtime, mtimecmp, a
// registered timer interrupt, and a single-cycle-ack 32-bit bus port.
module serv_mtimer
    import serv_mtimer_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] RESET_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, ack_d;
    logic        irq_q, irq_d;

    logic        access;
    logic        wr;
    logic        rd;
    logic        tick;

    logic [31:0] mrg_mtime_lo;
    logic [31:0] mrg_mtime_hi;
    logic [31:0] mrg_cmp_lo;
    logic [31:0] mrg_cmp_hi;

    serv_mtimer_bytewr u_mtime_lo (
        .i_old    (mtime_q[31:0]),
        .i_new    (i_wb_dat),
        .i_sel    (i_wb_sel),
        .o_merged (mrg_mtime_lo)
    );

    serv_mtimer_bytewr u_mtime_hi (
        .i_old    (mtime_q[63:32]),
        .i_new    (i_wb_dat),
        .i_sel    (i_wb_sel),
        .o_merged (mrg_mtime_hi)
    );

    serv_mtimer_bytewr u_cmp_lo (
        .i_old    (mtimecmp_q[31:0]),
        .i_new    (i_wb_dat),
        .i_sel    (i_wb_sel),
        .o_merged (mrg_cmp_lo)
    );

    serv_mtimer_bytewr u_cmp_hi (
        .i_old    (mtimecmp_q[63:32]),
        .i_new    (i_wb_dat),
        .i_sel    (i_wb_sel),
        .o_merged (mrg_cmp_hi)
    );

    // A cycle is accepted only when no ack is outstanding, so a held request
    // is acknowledged at most every other cycle.
    always_comb begin
        access = i_wb_cyc & ~ack_q;
        wr     = access & i_wb_we;
        rd     = access & ~i_wb_we;
        tick   = (presc_q == PRESC_LAST);

        ack_d      = access;
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        shadow_d   = shadow_q;
        rdt_d      = 32'd0;
        irq_d      = (mtime_q >= mtimecmp_q);

        // A bus write to mtime replaces the pending increment entirely.
        if (wr) begin
            case (i_wb_adr)
                MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], mrg_mtime_lo};
                    presc_d = 16'd0;
                end
                MTIME_HI: begin
                    mtime_d = {mrg_mtime_hi, mtime_q[31:0]};
                    presc_d = 16'd0;
                end
                MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], mrg_cmp_lo};
                default:     mtimecmp_d = {mrg_cmp_hi, mtimecmp_q[31:0]};
            endcase
        end

        if (rd) begin
            case (i_wb_adr)
                MTIME_LO: begin
                    rdt_d    = mtime_q[31:0];
                    shadow_d = mtime_q[63:32];
                end
                MTIME_HI:    rdt_d = shadow_q;
                MTIMECMP_LO: rdt_d = mtimecmp_q[31:0];
                default:     rdt_d = mtimecmp_q[63:32];
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= RESET_CMP;
            presc_q    <= 16'd0;
            shadow_q   <= 32'd0;
            rdt_q      <= 32'd0;
            ack_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            presc_q    <= presc_d;
            shadow_q   <= shadow_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            irq_q      <= irq_d;
        end
    end

    assign o_wb_ack    = ack_q;
    assign o_wb_rdt    = ack_q ? rdt_q : 32'd0;
    assign o_timer_irq = irq_q;

endmodule
